// File: rtl/cacc_dlv_addr_seq_if.sv
// Delivery-stream handshake bundle: buffer read atoms in, address-tagged atoms out.
interface cacc_dlv_addr_seq_if #(
  parameter int AW = 27
) ();
  logic          in_valid;
  logic          in_ready;
  logic          in_layer_end;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic          out_line_end;
  logic          out_surf_end;
  logic          out_layer_end;

  modport slave (
    input  in_valid, in_layer_end, out_ready,
    output in_ready, out_valid, out_addr, out_line_end, out_surf_end, out_layer_end
  );

  modport master (
    output in_valid, in_layer_end, out_ready,
    input  in_ready, out_valid, out_addr, out_line_end, out_surf_end, out_layer_end
  );
endinterface

// File: rtl/cacc_dlv_addr_seq.sv
// Tags each delivery-buffer atom with its surface address and line/surface/layer end flags.
// One-cycle register slice; input stalls only when the held atom is not being taken.
module cacc_dlv_addr_seq #(
  parameter int AW = 27,
  parameter int SW = 8
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          op_load,
  input  logic [12:0]   reg2dp_dataout_width,
  input  logic [12:0]   reg2dp_dataout_height,
  input  logic [SW-1:0] reg2dp_dataout_surf,
  input  logic [AW-1:0] reg2dp_dataout_addr,
  input  logic [23:0]   reg2dp_line_stride,
  input  logic [23:0]   reg2dp_surf_stride,
  cacc_dlv_addr_seq_if.slave io,
  output logic          busy,
  output logic          seq_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [12:0]   width_r, height_r;
  logic [SW-1:0] surf_r;
  logic [AW-1:0] line_stride_r, surf_stride_r;
  logic [12:0]   w_cnt, h_cnt;
  logic [SW-1:0] s_cnt;
  logic [AW-1:0] line_base, surf_base;

  logic accept;
  logic line_end_c, surf_end_c, layer_end_c;

  assign busy        = (state != ST_IDLE);
  assign io.in_ready = (state == ST_RUN) & (~io.out_valid | io.out_ready);
  assign accept      = io.in_valid & io.in_ready;

  assign line_end_c  = (w_cnt == width_r);
  assign surf_end_c  = line_end_c & (h_cnt == height_r);
  assign layer_end_c = surf_end_c & (s_cnt == surf_r);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state            <= ST_IDLE;
      width_r          <= '0;
      height_r         <= '0;
      surf_r           <= '0;
      line_stride_r    <= '0;
      surf_stride_r    <= '0;
      w_cnt            <= '0;
      h_cnt            <= '0;
      s_cnt            <= '0;
      line_base        <= '0;
      surf_base        <= '0;
      seq_err          <= 1'b0;
      io.out_valid     <= 1'b0;
      io.out_addr      <= '0;
      io.out_line_end  <= 1'b0;
      io.out_surf_end  <= 1'b0;
      io.out_layer_end <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_load) begin
            width_r       <= reg2dp_dataout_width;
            height_r      <= reg2dp_dataout_height;
            surf_r        <= reg2dp_dataout_surf;
            line_stride_r <= AW'(reg2dp_line_stride);
            surf_stride_r <= AW'(reg2dp_surf_stride);
            w_cnt         <= '0;
            h_cnt         <= '0;
            s_cnt         <= '0;
            line_base     <= reg2dp_dataout_addr;
            surf_base     <= reg2dp_dataout_addr;
            seq_err       <= 1'b0;
            state         <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (line_end_c) begin
              w_cnt <= '0;
              // Next surface starts at the advanced surface base, not the line walk.
              if (surf_end_c) begin
                h_cnt     <= '0;
                s_cnt     <= s_cnt + SW'(1);
                surf_base <= surf_base + surf_stride_r;
                line_base <= surf_base + surf_stride_r;
              end else begin
                h_cnt     <= h_cnt + 13'd1;
                line_base <= line_base + line_stride_r;
              end
            end else begin
              w_cnt <= w_cnt + 13'd1;
            end
            if (io.in_layer_end != layer_end_c) seq_err <= 1'b1;
            if (layer_end_c) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!io.out_valid || io.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        io.out_valid     <= 1'b1;
        io.out_addr      <= line_base + AW'(w_cnt);
        io.out_line_end  <= line_end_c;
        io.out_surf_end  <= surf_end_c;
        io.out_layer_end <= layer_end_c;
      end else if (io.out_ready) begin
        io.out_valid <= 1'b0;
      end
    end
  end

endmodule
